// File: rtl/flit_framer.sv
// Per-VC packet framer: decodes header format/length, marks sop/eop/len, drops unknown formats.
// Latency 1 cycle; in_ready = !out_valid || out_ready. Optional saturating error counter: FLIT_FRAMER_ERR_CNT_EN.
module flit_framer #(
  parameter int NUM_VC = 2,
  parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VC_W-1:0]   in_vc,
  input  logic [31:0]       in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VC_W-1:0]   out_vc,
  output logic [31:0]       out_payload,
  output logic              out_sop,
  output logic              out_eop,
  output logic [LEN_W-1:0]  out_len,
  input  logic [NUM_VC-1:0] flush_vc,
  output logic              err_fmt,
  output logic [15:0]       err_count,
  output logic [NUM_VC-1:0] vc_busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BODY = 1'b1} vc_state_e;

  vc_state_e        state_q [NUM_VC];
  vc_state_e        state_d [NUM_VC];
  logic [LEN_W-1:0] rem_q   [NUM_VC];
  logic [LEN_W-1:0] rem_d   [NUM_VC];

  logic             out_valid_q, out_valid_d;
  logic [VC_W-1:0]  out_vc_q, out_vc_d;
  logic [31:0]      out_payload_q, out_payload_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;
  logic             err_fmt_q, err_fmt_d;

  logic             accept;
  logic             vc_ok;
  vc_state_e        cur_state;
  logic [LEN_W-1:0] cur_rem;
  logic [LEN_W-1:0] hdr_len;
  logic [LEN_W-1:0] l7_ext;
  logic [LEN_W-1:0] l4_ext;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Header length decode; a zero result marks an unknown format.
  always_comb begin
    hdr_len = '0;
    l7_ext  = (in_payload[6:0] == 7'd0) ? LEN_W'(128) : LEN_W'(in_payload[6:0]);
    l4_ext  = (in_payload[3:0] == 4'd0) ? LEN_W'(16)  : LEN_W'(in_payload[3:0]);
    case (in_payload[31:28])
      4'h0:    hdr_len = LEN_W'(3);
      4'h1:    hdr_len = LEN_W'(3) + l7_ext;
      4'h2:    hdr_len = LEN_W'(2) + l7_ext;
      4'h3:    hdr_len = LEN_W'(2) + LEN_W'(in_payload[6:0]);
      4'h4:    hdr_len = LEN_W'(1);
      4'h8:    hdr_len = LEN_W'(2);
      4'h9:    hdr_len = LEN_W'(2) + l4_ext;
      4'hA:    hdr_len = LEN_W'(1);
      default: hdr_len = '0;
    endcase
  end

  // Context lookup by loop so an out-of-range in_vc never indexes the arrays.
  always_comb begin
    vc_ok     = 1'b0;
    cur_state = ST_IDLE;
    cur_rem   = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (in_vc == VC_W'(i)) begin
        vc_ok     = 1'b1;
        cur_state = state_q[i];
        cur_rem   = rem_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
    end
    out_valid_d   = out_valid_q && !out_ready;
    out_vc_d      = out_vc_q;
    out_payload_d = out_payload_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_len_d     = out_len_q;
    err_fmt_d     = 1'b0;

    if (accept) begin
      if (!vc_ok || (cur_state == ST_IDLE && hdr_len == '0)) begin
        err_fmt_d = 1'b1;
      end else begin
        out_valid_d   = 1'b1;
        out_vc_d      = in_vc;
        out_payload_d = in_payload;
        if (cur_state == ST_IDLE) begin
          out_sop_d = 1'b1;
          out_eop_d = (hdr_len == LEN_W'(1));
          out_len_d = hdr_len;
        end else begin
          out_sop_d = 1'b0;
          out_eop_d = (cur_rem == LEN_W'(1));
          out_len_d = '0;
        end
        for (int i = 0; i < NUM_VC; i++) begin
          if (in_vc == VC_W'(i)) begin
            if (cur_state == ST_IDLE) begin
              if (hdr_len != LEN_W'(1)) begin
                state_d[i] = ST_BODY;
                rem_d[i]   = hdr_len - LEN_W'(1);
              end
            end else begin
              rem_d[i] = cur_rem - LEN_W'(1);
              if (cur_rem == LEN_W'(1)) begin
                state_d[i] = ST_IDLE;
              end
            end
          end
        end
      end
    end

    // Flush overrides the context update but leaves the output register alone.
    for (int i = 0; i < NUM_VC; i++) begin
      if (flush_vc[i]) begin
        state_d[i] = ST_IDLE;
        rem_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= ST_IDLE;
        rem_q[i]   <= '0;
      end
      out_valid_q   <= 1'b0;
      out_vc_q      <= '0;
      out_payload_q <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_len_q     <= '0;
      err_fmt_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
      out_valid_q   <= out_valid_d;
      out_vc_q      <= out_vc_d;
      out_payload_q <= out_payload_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_len_q     <= out_len_d;
      err_fmt_q     <= err_fmt_d;
    end
  end

  always_comb begin
    vc_busy = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      vc_busy[i] = (state_q[i] == ST_BODY);
    end
  end

  assign out_valid   = out_valid_q;
  assign out_vc      = out_vc_q;
  assign out_payload = out_payload_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_len     = out_len_q;
  assign err_fmt     = err_fmt_q;

`ifdef FLIT_FRAMER_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Counts alongside the err_fmt register so both update on the same edge.
  always_comb begin
    err_count_d = err_count_q;
    if (err_fmt_d && err_count_q != 16'hFFFF) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_flit_framer.sv
// Scoreboard bench for flit_framer: a driver updates a per-VC remaining-count model and queues expected flits; a monitor checks outputs.
module tb_flit_framer;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 1;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              in_valid;
  logic              in_ready;
  logic [VC_W-1:0]   in_vc;
  logic [31:0]       in_payload;
  logic              out_valid;
  logic              out_ready;
  logic [VC_W-1:0]   out_vc;
  logic [31:0]       out_payload;
  logic              out_sop;
  logic              out_eop;
  logic [LEN_W-1:0]  out_len;
  logic [NUM_VC-1:0] flush_vc;
  logic              err_fmt;
  logic [15:0]       err_count;
  logic [NUM_VC-1:0] vc_busy;

  always #5 clk = ~clk;

  flit_framer #(.NUM_VC(NUM_VC), .VC_W(VC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vc(in_vc), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_vc(out_vc), .out_payload(out_payload),
    .out_sop(out_sop), .out_eop(out_eop), .out_len(out_len),
    .flush_vc(flush_vc), .err_fmt(err_fmt), .err_count(err_count), .vc_busy(vc_busy)
  );

  typedef struct packed {
    logic [VC_W-1:0]  vc;
    logic [31:0]      pay;
    logic             sop;
    logic             eop;
    logic [LEN_W-1:0] len;
  } exp_t;

  exp_t              exp_q[$];
  int                rem_m[NUM_VC];
  int                err_total;
  int                total;
  int                bad;
  bit                err_nxt, err_cur;
  logic [NUM_VC-1:0] busy_nxt, busy_cur;
  bit                mon_en;
  bit                rnd_rdy;
  bit                acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Packet length straight from the header format table.
  function automatic int model_len(input logic [31:0] p);
    int l7, l4;
    l7 = int'(p[6:0]);
    l4 = int'(p[3:0]);
    case (p[31:28])
      4'h0:    return 3;
      4'h1:    return 3 + ((l7 == 0) ? 128 : l7);
      4'h2:    return 2 + ((l7 == 0) ? 128 : l7);
      4'h3:    return 2 + l7;
      4'h4:    return 1;
      4'h8:    return 2;
      4'h9:    return 2 + ((l4 == 0) ? 16 : l4);
      4'hA:    return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_accept(input int vc, input logic [31:0] p);
    int n;
    if (rem_m[vc] == 0) begin
      n = model_len(p);
      if (n == 0) begin
        err_nxt = 1'b1;
        err_total++;
      end else begin
        exp_q.push_back('{vc: VC_W'(vc), pay: p, sop: 1'b1, eop: (n == 1), len: LEN_W'(n)});
        rem_m[vc] = n - 1;
      end
    end else begin
      exp_q.push_back('{vc: VC_W'(vc), pay: p, sop: 1'b0, eop: (rem_m[vc] == 1), len: '0});
      rem_m[vc] = rem_m[vc] - 1;
    end
  endtask

  // One clock of stimulus; acceptance is judged just before the edge that takes the flit.
  task automatic step(input bit v, input int vc, input logic [31:0] p,
                      input logic [NUM_VC-1:0] fl, input bit ordy, output bit a);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_vc      = VC_W'(vc);
    in_payload = p;
    flush_vc   = fl;
    out_ready  = ordy;
    @(negedge clk);
    a = v && in_ready;
    err_nxt = 1'b0;
    if (a) model_accept(vc, p);
    for (int i = 0; i < NUM_VC; i++) begin
      if (fl[i]) rem_m[i] = 0;
      busy_nxt[i] = (rem_m[i] != 0);
    end
  endtask

  function automatic bit pick_rdy();
    if (!rnd_rdy) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic send(input int vc, input logic [31:0] p, input logic [NUM_VC-1:0] fl);
    int tries;
    logic [NUM_VC-1:0] f;
    bit a;
    tries = 0;
    f = fl;
    do begin
      step(1'b1, vc, p, f, pick_rdy(), a);
      f = '0;
      tries++;
    end while (!a && tries < 100);
    if (!a) chk("send_timeout", 64'(tries), 64'(0));
  endtask

  task automatic drain();
    int g;
    bit a;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      step(1'b0, 0, 32'h0, '0, 1'b1, a);
      g++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (2) step(1'b0, 0, 32'h0, '0, 1'b1, a);
  endtask

  function automatic logic [31:0] rand_hdr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: r[31:28] = 4'h0;
      1: r[31:28] = 4'h1;
      2: r[31:28] = 4'h2;
      3: r[31:28] = 4'h3;
      4: r[31:28] = 4'h4;
      5: r[31:28] = 4'h8;
      6: r[31:28] = 4'h9;
      7: r[31:28] = 4'hA;
      8: r[31:28] = 4'h5;
      default: r[31:28] = 4'hF;
    endcase
    if ($urandom_range(0, 7) != 0) r[6:0] = 7'($urandom_range(0, 10));
    return r;
  endfunction

  // Monitor: compares the displayed flit against the queue head every valid cycle, pops on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (n_rst && mon_en) begin
        chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        chk("err_fmt", 64'(err_fmt), 64'(err_cur));
        chk("vc_busy", 64'(vc_busy), 64'(busy_cur));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("out_unexpected", 64'(out_payload), 64'hDEAD_0000_0000);
          end else begin
            e = exp_q[0];
            chk("out_flit", 64'({out_vc, out_payload, out_sop, out_eop, out_len}), 64'(e));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
      err_cur  = err_nxt;
      busy_cur = busy_nxt;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, vc, cnt;
    logic [31:0] p;
    logic [NUM_VC-1:0] fl;
    int exp_cnt;

    total = 0; bad = 0; err_total = 0;
    mon_en = 1'b0; rnd_rdy = 1'b0;
    err_nxt = 1'b0; err_cur = 1'b0; busy_nxt = '0; busy_cur = '0;
    for (int i = 0; i < NUM_VC; i++) rem_m[i] = 0;
    n_rst = 1'b0; in_valid = 1'b0; in_vc = '0; in_payload = '0; flush_vc = '0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_fields", 64'({out_vc, out_payload, out_sop, out_eop, out_len}), 64'(0));
    chk("rst_err", 64'({err_fmt, err_count}), 64'(0));
    chk("rst_vc_busy", 64'(vc_busy), 64'(0));
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    mon_en = 1'b1;

    // Short write: 5 flits.
    send(0, 32'h9000_0003, '0);
    for (int i = 0; i < 4; i++) send(0, $urandom, '0);
    drain();

    // Long write with L7=0: 131 flits.
    send(0, 32'h1000_0000, '0);
    for (int i = 0; i < 130; i++) send(0, $urandom, '0);
    drain();

    // Interleaved long read on VC0 and switch cfg on VC1.
    send(0, 32'h0000_0000, '0);
    send(1, 32'h4000_0000, '0);
    send(0, 32'h1234_5678, '0);
    send(1, 32'h4000_0000, '0);
    send(0, 32'h8765_4321, '0);
    drain();

    // Unknown format.
    send(0, 32'h5000_0000, '0);
    drain();

    // Stall mid-packet.
    send(0, 32'h9000_0002, '0);
    send(0, 32'hAAAA_0001, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 0, 32'hAAAA_0002, '0, 1'b0, acc);
      chk("stall_accept", 64'(acc), 64'(0));
    end
    send(0, 32'hAAAA_0002, '0);
    send(0, 32'hAAAA_0003, '0);
    drain();

    // Flush after the 2nd flit, then a fresh header.
    send(0, 32'h9000_0003, '0);
    send(0, 32'hBBBB_0001, '0);
    step(1'b0, 0, 32'h0, 2'b01, 1'b1, acc);
    step(1'b0, 0, 32'h0, 2'b00, 1'b1, acc);
    send(0, 32'h4000_0000, '0);
    drain();

    // Flush coinciding with an accepted body flit on VC1.
    send(1, 32'h9000_0001, '0);
    send(1, 32'hCCCC_0001, 2'b10);
    send(1, 32'hA000_0000, '0);
    drain();

    // Randomized traffic with random backpressure and occasional flushes.
    rnd_rdy = 1'b1;
    for (int s = 0; s < 1500; s++) begin
      v  = ($urandom_range(0, 6) != 0);
      vc = $urandom_range(0, NUM_VC - 1);
      p  = (rem_m[vc] == 0) ? rand_hdr() : $urandom;
      fl = ($urandom_range(0, 40) == 0) ? NUM_VC'($urandom_range(1, (1 << NUM_VC) - 1)) : '0;
      step(v[0], vc, p, fl, pick_rdy(), acc);
    end
    rnd_rdy = 1'b0;
    drain();

`ifdef FLIT_FRAMER_ERR_CNT_EN
    exp_cnt = (err_total > 65535) ? 65535 : err_total;
`else
    exp_cnt = 0;
`endif
    cnt = int'(err_count);
    chk("err_count", 64'(cnt), 64'(exp_cnt));
    chk("err_seen", 64'(err_total > 0), 64'(1));

    // Reset while a packet is in flight and the output register is stalled.
    send(0, 32'h9000_0003, '0);
    send(0, 32'hDDDD_0001, '0);
    step(1'b0, 0, 32'h0, '0, 1'b0, acc);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_fields", 64'({out_vc, out_payload, out_sop, out_eop, out_len}), 64'(0));
    chk("mid_rst_err", 64'({err_fmt, err_count}), 64'(0));
    chk("mid_rst_vc_busy", 64'(vc_busy), 64'(0));
    exp_q.delete();
    for (int i = 0; i < NUM_VC; i++) rem_m[i] = 0;
    err_nxt = 1'b0; err_cur = 1'b0; busy_nxt = '0; busy_cur = '0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    mon_en = 1'b1;
    send(0, 32'h4000_0000, '0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
